// File: rtl/netlist_pkg.sv
// Shared types for the runtime-loadable garbled-circuit netlist store.
// The gate descriptor is fixed at NL_S-bit wire indices.
package netlist_pkg;

   localparam int NL_S          = 20;
   localparam int NL_DEPTH      = 4096;
   localparam int NL_INPUT_SIZE = 16;

   typedef struct packed {
      logic [NL_S-1:0] in0;
      logic [NL_S-1:0] in1;
      logic [3:0]      g_logic;
   } gate_desc_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_READY
   } ldr_state_e;

endpackage

// File: rtl/netlist_ram.sv
// Gate descriptor storage: one write port, one registered read port.
// Storage is deliberately not reset.
module netlist_ram
   import netlist_pkg::*;
#(
   parameter int DEPTH = NL_DEPTH,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  gate_desc_t    i_wr_data,
   input  logic          i_rd_en,
   input  logic [AW-1:0] i_rd_addr,
   output gate_desc_t    o_rd_data
);

   gate_desc_t r_mem [DEPTH];
   gate_desc_t r_rd_data;

   // Read data only moves on a read, so the last lookup result is held.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
      if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/netlist_loader.sv
// Loads a stream of gate descriptors into gate-indexed memory, checks for
// forward references, and serves gid lookups once the netlist is complete.
module netlist_loader
   import netlist_pkg::*;
#(
   parameter int S          = NL_S,
   parameter int DEPTH      = NL_DEPTH,
   parameter int INPUT_SIZE = NL_INPUT_SIZE
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_start,
   input  logic [S-1:0] load_num,
   input  logic         wr_valid,
   output logic         wr_ready,
   input  logic [S-1:0] wr_in0,
   input  logic [S-1:0] wr_in1,
   input  logic [3:0]   wr_logic,
   output logic         loaded,
   output logic         err,
   input  logic         rd_en,
   input  logic [S-1:0] rd_gid,
   output logic         rd_valid,
   output logic         rd_oob,
   output logic [S-1:0] in0,
   output logic [S-1:0] in1,
   output logic         in0F,
   output logic         in1F,
   output logic [3:0]   g_logic
);

   localparam int           AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [S:0]   LIM_BASE  = (S+1)'(INPUT_SIZE);
   localparam logic [S:0]   DEPTH_MAX = (S+1)'(DEPTH);
   localparam logic [S-1:0] ISZ       = S'(INPUT_SIZE);

   ldr_state_e   r_state;
   logic [S-1:0] r_count;
   logic [S-1:0] r_num;
   logic         r_wr_ready;
   logic         r_loaded;
   logic         r_err;
   logic         r_rd_valid;
   logic         r_rd_oob;
   logic         r_rd_seen;

   logic         w_beat;
   logic         w_last;
   logic         w_fwd_ref;
   logic         w_oversize;
   logic         w_rd_accept;
   logic         w_rd_oob;
   logic         w_show;
   logic [S:0]   w_limit;
   gate_desc_t   w_wr_desc;
   gate_desc_t   w_rd_desc;

   assign w_beat      = (r_state == ST_LOAD) && wr_valid && r_wr_ready;
   assign w_last      = (r_count == r_num - 1'b1);
   assign w_limit     = LIM_BASE + {1'b0, r_count};
   assign w_fwd_ref   = ({1'b0, wr_in0} >= w_limit) || ({1'b0, wr_in1} >= w_limit);
   assign w_oversize  = ({1'b0, load_num} > DEPTH_MAX);
   assign w_rd_accept = rd_en && (r_state == ST_READY);
   assign w_rd_oob    = (rd_gid >= r_num);

   assign w_wr_desc.in0     = wr_in0;
   assign w_wr_desc.in1     = wr_in1;
   assign w_wr_desc.g_logic = wr_logic;

   netlist_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk       (clk),
      .i_wr_en   (w_beat),
      .i_wr_addr (r_count[AW-1:0]),
      .i_wr_data (w_wr_desc),
      .i_rd_en   (w_rd_accept),
      .i_rd_addr (rd_gid[AW-1:0]),
      .o_rd_data (w_rd_desc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_count    <= '0;
         r_num      <= '0;
         r_wr_ready <= 1'b0;
         r_loaded   <= 1'b0;
         r_err      <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_oob   <= 1'b0;
         r_rd_seen  <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_accept;
         if (w_rd_accept) begin
            r_rd_oob  <= w_rd_oob;
            r_rd_seen <= 1'b1;
         end

         case (r_state)
            ST_IDLE, ST_READY: begin
               if (load_start) begin
                  r_num    <= load_num;
                  r_count  <= '0;
                  r_loaded <= 1'b0;
                  r_err    <= w_oversize;
                  if (w_oversize) begin
                     r_state    <= ST_IDLE;
                     r_wr_ready <= 1'b0;
                  end else if (load_num == '0) begin
                     r_state  <= ST_READY;
                     r_loaded <= 1'b1;
                  end else begin
                     r_state    <= ST_LOAD;
                     r_wr_ready <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               // Offending beats are still stored and counted; err just flags them.
               if (w_beat) begin
                  r_count <= r_count + 1'b1;
                  if (w_fwd_ref) begin
                     r_err <= 1'b1;
                  end
                  if (w_last) begin
                     r_state    <= ST_READY;
                     r_loaded   <= 1'b1;
                     r_wr_ready <= 1'b0;
                  end
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_wr_ready <= 1'b0;
            end
         endcase
      end
   end

   // Before any lookup, and for out-of-range gids, the data outputs read as zero.
   assign w_show   = r_rd_seen && !r_rd_oob;
   assign in0      = w_show ? w_rd_desc.in0     : '0;
   assign in1      = w_show ? w_rd_desc.in1     : '0;
   assign g_logic  = w_show ? w_rd_desc.g_logic : '0;
   assign in0F     = r_rd_seen && (in0 < ISZ);
   assign in1F     = r_rd_seen && (in1 < ISZ);

   assign wr_ready = r_wr_ready;
   assign loaded   = r_loaded;
   assign err      = r_err;
   assign rd_valid = r_rd_valid;
   assign rd_oob   = r_rd_oob;

endmodule

// File: tb/tb_netlist_loader.sv
// Self-checking bench for netlist_loader: randomized loads and lookups
// compared against an array-based model of the netlist store.
module tb_netlist_loader;

   localparam int S     = 20;
   localparam int DEPTH = 4096;
   localparam int ISZ   = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         load_start = 1'b0;
   logic [S-1:0] load_num = '0;
   logic         wr_valid = 1'b0;
   logic         wr_ready;
   logic [S-1:0] wr_in0 = '0;
   logic [S-1:0] wr_in1 = '0;
   logic [3:0]   wr_logic = '0;
   logic         loaded;
   logic         err;
   logic         rd_en = 1'b0;
   logic [S-1:0] rd_gid = '0;
   logic         rd_valid;
   logic         rd_oob;
   logic [S-1:0] in0;
   logic [S-1:0] in1;
   logic         in0F;
   logic         in1F;
   logic [3:0]   g_logic;

   int checks   = 0;
   int failures = 0;

   // Reference model: what the store should hold and report.
   logic [S-1:0] m_in0 [DEPTH];
   logic [S-1:0] m_in1 [DEPTH];
   logic [3:0]   m_lg  [DEPTH];
   int           m_num = 0;
   bit           m_err = 1'b0;

   // Stimulus gate list for the next load.
   logic [S-1:0] s_in0 [64];
   logic [S-1:0] s_in1 [64];
   logic [3:0]   s_lg  [64];

   netlist_loader dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .load_num   (load_num),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_in0     (wr_in0),
      .wr_in1     (wr_in1),
      .wr_logic   (wr_logic),
      .loaded     (loaded),
      .err        (err),
      .rd_en      (rd_en),
      .rd_gid     (rd_gid),
      .rd_valid   (rd_valid),
      .rd_oob     (rd_oob),
      .in0        (in0),
      .in1        (in1),
      .in0F       (in0F),
      .in1F       (in1F),
      .g_logic    (g_logic)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2*S+7:0] exp_rd(input logic [S-1:0] gid);
      if (int'(gid) >= m_num)
         return {1'b1, 1'b1, {S{1'b0}}, {S{1'b0}}, 4'h0, 1'b1, 1'b1};
      return {1'b1, 1'b0, m_in0[gid], m_in1[gid], m_lg[gid],
              (int'(m_in0[gid]) < ISZ), (int'(m_in1[gid]) < ISZ)};
   endfunction

   task automatic gen_gates(input int n);
      for (int k = 0; k < n; k++) begin
         s_in0[k] = S'($urandom_range(0, ISZ + k - 1));
         s_in1[k] = S'($urandom_range(0, ISZ + k - 1));
         s_lg[k]  = 4'($urandom_range(0, 15));
      end
   endtask

   task automatic start_load(input int n);
      load_start = 1'b1;
      load_num   = S'(n);
      tick();
      load_start = 1'b0;
      m_num = n;
      m_err = (n > DEPTH);
   endtask

   task automatic send_gates(input int n, input bit rand_valid);
      int  k   = 0;
      int  cyc = 0;
      bit  acc;
      while (k < n && cyc < 1000) begin
         wr_valid = rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
         wr_in0   = s_in0[k];
         wr_in1   = s_in1[k];
         wr_logic = s_lg[k];
         acc      = wr_valid && wr_ready;
         tick();
         cyc++;
         if (acc) begin
            m_in0[k] = s_in0[k];
            m_in1[k] = s_in1[k];
            m_lg[k]  = s_lg[k];
            if (int'(s_in0[k]) >= ISZ + k || int'(s_in1[k]) >= ISZ + k) m_err = 1'b1;
            k++;
         end
      end
      wr_valid = 1'b0;
      checks++;
      if (k != n) begin
         failures++;
         $display("FAIL send_beats: accepted=%0d required=%0d", k, n);
      end
   endtask

   task automatic read_check(input logic [S-1:0] gid, input string name);
      logic [2*S+7:0] exp;
      logic [2*S+7:0] got;
      exp    = exp_rd(gid);
      rd_en  = 1'b1;
      rd_gid = gid;
      tick();
      rd_en  = 1'b0;
      got    = {rd_valid, rd_oob, in0, in1, g_logic, in0F, in1F};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s gid=%0d: got=%h required=%h", name, gid, got, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if ({wr_ready, loaded, err, rd_valid, rd_oob, in0, in1, g_logic, in0F, in1F} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: wr_ready=%b loaded=%b err=%b rd_valid=%b rd_oob=%b in0=%0d in1=%0d g=%h f=%b%b required all 0",
                  wr_ready, loaded, err, rd_valid, rd_oob, in0, in1, g_logic, in0F, in1F);
      end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      checks++;
      if (rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL idle_read_ignored: rd_valid=%b required 0", rd_valid);
      end
   endtask

   task automatic test_basic();
      s_in0[0] = 20'd0;  s_in1[0] = 20'd1;  s_lg[0] = 4'h8;
      s_in0[1] = 20'd2;  s_in1[1] = 20'd3;  s_lg[1] = 4'h6;
      s_in0[2] = 20'd16; s_in1[2] = 20'd17; s_lg[2] = 4'h8;
      start_load(3);
      send_gates(3, 1'b0);
      checks++;
      if ({wr_ready, loaded, err} !== 3'b010) begin
         failures++;
         $display("FAIL basic_done: wr_ready/loaded/err=%b required 010", {wr_ready, loaded, err});
      end
      rd_en  = 1'b1;
      rd_gid = 20'd2;
      tick();
      rd_en  = 1'b0;
      checks++;
      if ({rd_valid, rd_oob, in0, in1, g_logic, in0F, in1F} !== {1'b1, 1'b0, 20'd16, 20'd17, 4'h8, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL basic_read gid=2: valid=%b oob=%b in0=%0d in1=%0d g=%h f=%b%b required 1 0 16 17 8 00",
                  rd_valid, rd_oob, in0, in1, g_logic, in0F, in1F);
      end
      read_check(20'd0, "basic_read0");
      read_check(20'd1, "basic_read1");
   endtask

   task automatic test_random_load();
      int n;
      n = $urandom_range(10, 40);
      gen_gates(n);
      start_load(n);
      send_gates(n, 1'b1);
      checks++;
      if ({wr_ready, loaded, err} !== {1'b0, 1'b1, m_err}) begin
         failures++;
         $display("FAIL random_done n=%0d: wr_ready/loaded/err=%b required 01%b", n, {wr_ready, loaded, err}, m_err);
      end
      for (int i = 0; i < 12; i++) begin
         read_check(S'($urandom_range(0, n + 2)), "random_read");
      end
   endtask

   task automatic test_fwd_ref();
      s_in0[0] = 20'd16; s_in1[0] = 20'd0; s_lg[0] = 4'h5;
      s_in0[1] = 20'd1;  s_in1[1] = 20'd2; s_lg[1] = 4'h3;
      start_load(2);
      send_gates(2, 1'b0);
      checks++;
      if ({loaded, err} !== {1'b1, m_err} || m_err !== 1'b1) begin
         failures++;
         $display("FAIL fwd_ref_err: loaded/err=%b required 11", {loaded, err});
      end
      read_check(20'd0, "fwd_ref_read");
      start_load(1);
      checks++;
      if ({wr_ready, loaded, err} !== 3'b100) begin
         failures++;
         $display("FAIL fwd_ref_clear: wr_ready/loaded/err=%b required 100", {wr_ready, loaded, err});
      end
      gen_gates(1);
      send_gates(1, 1'b0);
   endtask

   task automatic test_oob_back_to_back();
      logic [2*S+7:0] exp [3];
      logic [2*S+7:0] got;
      gen_gates(3);
      start_load(3);
      send_gates(3, 1'b1);
      read_check(20'd3, "oob_num");
      read_check(20'hFFFFF, "oob_max");
      for (int i = 0; i < 3; i++) exp[i] = exp_rd(S'(i));
      rd_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rd_gid = S'(i);
         tick();
         if (i == 2) rd_en = 1'b0;
         got = {rd_valid, rd_oob, in0, in1, g_logic, in0F, in1F};
         checks++;
         if (got !== exp[i]) begin
            failures++;
            $display("FAIL b2b_read gid=%0d: got=%h required=%h", i, got, exp[i]);
         end
      end
      tick();
      checks++;
      if (rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_pulse_end: rd_valid=%b required 0", rd_valid);
      end
   endtask

   task automatic test_reset_midload();
      gen_gates(5);
      start_load(5);
      send_gates(2, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_num = 0;
      m_err = 1'b0;
      checks++;
      if ({wr_ready, loaded, err} !== 3'b000) begin
         failures++;
         $display("FAIL midload_rst: wr_ready/loaded/err=%b required 000", {wr_ready, loaded, err});
      end
      wr_valid = 1'b1;
      rd_en    = 1'b1;
      tick();
      wr_valid = 1'b0;
      rd_en    = 1'b0;
      checks++;
      if ({wr_ready, rd_valid} !== 2'b00) begin
         failures++;
         $display("FAIL midload_quiet: wr_ready/rd_valid=%b required 00", {wr_ready, rd_valid});
      end
      gen_gates(5);
      start_load(5);
      send_gates(5, 1'b1);
      checks++;
      if ({wr_ready, loaded, err} !== 3'b010) begin
         failures++;
         $display("FAIL reload_done: wr_ready/loaded/err=%b required 010", {wr_ready, loaded, err});
      end
      for (int i = 0; i < 5; i++) read_check(S'(i), "reload_read");
   endtask

   task automatic test_zero_oversize();
      start_load(0);
      checks++;
      if ({wr_ready, loaded, err} !== 3'b010) begin
         failures++;
         $display("FAIL zero_load: wr_ready/loaded/err=%b required 010", {wr_ready, loaded, err});
      end
      read_check(20'd0, "zero_read");
      start_load(DEPTH + 1);
      checks++;
      if ({wr_ready, loaded, err} !== {2'b00, m_err} || m_err !== 1'b1) begin
         failures++;
         $display("FAIL oversize: wr_ready/loaded/err=%b required 001", {wr_ready, loaded, err});
      end
      rd_en = 1'b1;
      tick();
      tick();
      rd_en = 1'b0;
      checks++;
      if ({wr_ready, loaded, err, rd_valid} !== 4'b0010) begin
         failures++;
         $display("FAIL oversize_hold: wr_ready/loaded/err/rd_valid=%b required 0010",
                  {wr_ready, loaded, err, rd_valid});
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_random_load();
      test_random_load();
      test_fwd_ref();
      test_oob_back_to_back();
      test_reset_midload();
      test_zero_oversize();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
